// File: rtl/conv_pkg.sv
// Shared types and constants for the convolution output serializer.
package conv_pkg;

    localparam int ACC_W = 32;
    localparam int PIX_W = 8;

    localparam logic signed [PIX_W-1:0] PIX_MAX = 8'sh7F;
    localparam logic signed [PIX_W-1:0] PIX_MIN = 8'sh80;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

endpackage

// File: rtl/requant_sat.sv
// Requantizes one signed 32-bit accumulator to a signed 8-bit pixel:
// optional clamp of negatives (RELU_EN), round half up, arithmetic shift,
// saturate to the pixel range. Purely combinational.
// Build option: define RELU_EN to clamp negative accumulators to zero.
module requant_sat
    import conv_pkg::*;
#(
    parameter int RQ_SHIFT = 8
) (
    input  logic signed [ACC_W-1:0] i_acc,
    output logic signed [PIX_W-1:0] o_pix
);

    localparam int RND_SH = (RQ_SHIFT > 0) ? RQ_SHIFT - 1 : 0;
    localparam logic signed [ACC_W:0] RND = (RQ_SHIFT > 0) ? (33'sd1 <<< RND_SH) : 33'sd0;

    logic signed [ACC_W-1:0] w_relu;
    logic signed [ACC_W:0]   w_ext;
    logic signed [ACC_W:0]   w_sum;
    logic signed [ACC_W:0]   w_shr;

`ifdef RELU_EN
    assign w_relu = i_acc[ACC_W-1] ? '0 : i_acc;
`else
    assign w_relu = i_acc;
`endif

    // One extra bit keeps the rounding add from overflowing at the top of the range.
    assign w_ext = {w_relu[ACC_W-1], w_relu};
    assign w_sum = w_ext + RND;
    assign w_shr = w_sum >>> RQ_SHIFT;

    // Saturate the shifted value into the 8-bit pixel range.
    always_comb begin
        o_pix = w_shr[PIX_W-1:0];
        if (w_shr > 33'(PIX_MAX)) begin
            o_pix = PIX_MAX;
        end else if (w_shr < 33'(PIX_MIN)) begin
            o_pix = PIX_MIN;
        end
    end

endmodule

// File: rtl/conv_output_serializer.sv
// Serializes NUM_TREES 32-bit accumulator lanes per input word into
// requantized 8-bit pixels, lane 0 first, over valid/ready handshakes.
// An active + pending word buffer lets the next word land while the
// current one drains, so back-to-back words emit without bubbles.
// Build option: RELU_EN (passed to requant_sat) clamps negative lanes to zero.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | active buffer empty, nothing presented, waiting for a word
// EMIT  | presenting lane tree_idx of the active word
module conv_output_serializer
    import conv_pkg::*;
#(
    parameter int NUM_TREES = 4,
    parameter int RQ_SHIFT  = 8
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [ACC_W*NUM_TREES-1:0]    acc_in,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic signed [PIX_W-1:0]       pixel_out,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          out_last
);

    localparam int IDX_W = (NUM_TREES > 1) ? $clog2(NUM_TREES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TREES - 1);

    state_t                              r_state;
    state_t                              w_state_nxt;
    logic [NUM_TREES-1:0][ACC_W-1:0]     r_active;
    logic [NUM_TREES-1:0][ACC_W-1:0]     w_active_nxt;
    logic [NUM_TREES-1:0][ACC_W-1:0]     r_pending;
    logic [NUM_TREES-1:0][ACC_W-1:0]     w_pending_nxt;
    logic                                r_pending_full;
    logic                                w_pending_full_nxt;
    logic [IDX_W-1:0]                    r_tree_idx;
    logic [IDX_W-1:0]                    w_tree_idx_nxt;

    logic                                w_in_fire;
    logic                                w_out_fire;
    logic                                w_last_lane;
    logic [ACC_W-1:0]                    w_lane;
    logic signed [PIX_W-1:0]             w_pix;

    // All outputs come from registered state; acc_in/in_valid never reach them.
    assign in_ready    = !r_pending_full;
    assign out_valid   = (r_state == EMIT);
    assign w_last_lane = (r_tree_idx == LAST_IDX);
    assign out_last    = out_valid && w_last_lane;
    assign pixel_out   = out_valid ? w_pix : '0;

    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = out_valid && out_ready;

    // Select the active lane addressed by tree_idx for requantization.
    always_comb begin
        w_lane = '0;
        for (int i = 0; i < NUM_TREES; i++) begin
            if (r_tree_idx == IDX_W'(i)) begin
                w_lane = r_active[i];
            end
        end
    end

    requant_sat #(
        .RQ_SHIFT (RQ_SHIFT)
    ) u_requant_sat (
        .i_acc (w_lane),
        .o_pix (w_pix)
    );

    // Next-state and buffer routing: last-lane handoff first, then input routing.
    always_comb begin
        w_state_nxt        = r_state;
        w_active_nxt       = r_active;
        w_pending_nxt      = r_pending;
        w_pending_full_nxt = r_pending_full;
        w_tree_idx_nxt     = r_tree_idx;

        case (r_state)
            IDLE: begin
                if (w_in_fire) begin
                    w_active_nxt   = acc_in;
                    w_tree_idx_nxt = '0;
                    w_state_nxt    = EMIT;
                end
            end
            EMIT: begin
                if (w_out_fire) begin
                    if (w_last_lane) begin
                        w_tree_idx_nxt = '0;
                        if (r_pending_full) begin
                            w_active_nxt       = r_pending;
                            w_pending_full_nxt = 1'b0;
                        end else if (w_in_fire) begin
                            w_active_nxt = acc_in;
                        end else begin
                            w_state_nxt = IDLE;
                        end
                    end else begin
                        w_tree_idx_nxt = r_tree_idx + IDX_W'(1);
                    end
                end
                // A word arriving with the last-lane handshake went straight to active above.
                if (w_in_fire && !(w_out_fire && w_last_lane)) begin
                    w_pending_nxt      = acc_in;
                    w_pending_full_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State and buffer registers with synchronous reset that drops any partial word.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state        <= IDLE;
            r_active       <= '0;
            r_pending      <= '0;
            r_pending_full <= 1'b0;
            r_tree_idx     <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_active       <= w_active_nxt;
            r_pending      <= w_pending_nxt;
            r_pending_full <= w_pending_full_nxt;
            r_tree_idx     <= w_tree_idx_nxt;
        end
    end

endmodule

// File: tb/tb_conv_output_serializer.sv
// Self-checking bench for conv_output_serializer: a 4-lane/shift-8 instance
// and a 1-lane/shift-0 instance, checked against a queue-based pixel model.
module tb_conv_output_serializer;

    localparam int NT  = 4;
    localparam int SH  = 8;
    localparam int NT1 = 1;
    localparam int SH1 = 0;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic [32*NT-1:0]  acc_a = '0;
    logic              iv_a = 1'b0, ir_a, ov_a, ol_a, or_a = 1'b0;
    logic [7:0]        px_a;
    logic [32*NT1-1:0] acc_b = '0;
    logic              iv_b = 1'b0, ir_b, ov_b, ol_b, or_b = 1'b0;
    logic [7:0]        px_b;

    conv_output_serializer #(.NUM_TREES(NT), .RQ_SHIFT(SH)) dut (
        .clock(clock), .reset(reset), .acc_in(acc_a), .in_valid(iv_a), .in_ready(ir_a),
        .pixel_out(px_a), .out_valid(ov_a), .out_ready(or_a), .out_last(ol_a));

    conv_output_serializer #(.NUM_TREES(NT1), .RQ_SHIFT(SH1)) dut1 (
        .clock(clock), .reset(reset), .acc_in(acc_b), .in_valid(iv_b), .in_ready(ir_b),
        .pixel_out(px_b), .out_valid(ov_b), .out_ready(or_b), .out_last(ol_b));

    typedef struct {
        logic [7:0] pix;
        logic       last;
    } exp_t;

    exp_t       q[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    int         lanes[NT];
    logic       held_v = 1'b0;
    logic [7:0] held_px;
    logic       held_last;
    logic       obs_ov;
    logic       in_fired;

    // Reference requantization in plain 64-bit arithmetic.
    function automatic logic [7:0] ref_pix(input int acc, input int sh);
        longint v;
        v = acc;
`ifdef RELU_EN
        if (v < 0) v = 0;
`endif
        if (sh > 0) v = v + (longint'(1) << (sh - 1));
        v = v >>> sh;
        if (v > 127) v = 127;
        if (v < -128) v = -128;
        return 8'(v);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic rand_lanes();
        for (int i = 0; i < NT; i++) begin
            if ($urandom_range(0, 3) == 0) lanes[i] = int'($urandom);
            else lanes[i] = int'($urandom_range(0, 65535)) - 32768;
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the model, advance.
    task automatic step(input int sel, input logic v, input logic rdy);
        int nt, sh, nw;
        logic ov, ir, ol;
        logic [7:0] px;
        exp_t e;
        nt = (sel != 0) ? NT1 : NT;
        sh = (sel != 0) ? SH1 : SH;
        if (sel == 0) begin
            iv_a = v; or_a = rdy;
            for (int i = 0; i < NT; i++) acc_a[32*i +: 32] = lanes[i];
            iv_b = 1'b0; or_b = 1'b0;
        end else begin
            iv_b = v; or_b = rdy; acc_b = lanes[0];
            iv_a = 1'b0; or_a = 1'b0;
        end
        #1;
        ov = (sel != 0) ? ov_b : ov_a;
        ir = (sel != 0) ? ir_b : ir_a;
        ol = (sel != 0) ? ol_b : ol_a;
        px = (sel != 0) ? px_b : px_a;
        nw = 0;
        foreach (q[k]) if (q[k].last) nw++;
        chk("in_ready", 32'(ir), 32'(nw < 2));
        chk("out_valid", 32'(ov), 32'(q.size() > 0));
        if (held_v) begin
            chk("hold_pixel", 32'(px), 32'(held_px));
            chk("hold_last", 32'(ol), 32'(held_last));
        end
        obs_ov   = ov;
        in_fired = v && ir;
        if (ov && rdy && q.size() > 0) begin
            e = q.pop_front();
            chk("pixel", 32'(px), 32'(e.pix));
            chk("last", 32'(ol), 32'(e.last));
        end
        if (v && ir) begin
            for (int i = 0; i < nt; i++) begin
                e.pix  = ref_pix(lanes[i], sh);
                e.last = (i == nt - 1);
                q.push_back(e);
            end
        end
        held_v    = ov && !rdy;
        held_px   = px;
        held_last = ol;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        iv_a = 1'b0; or_a = 1'b0; iv_b = 1'b0; or_b = 1'b0;
        @(posedge clock);
        #1;
        chk("rst_out_valid", 32'(ov_a), 32'd0);
        chk("rst_out_last", 32'(ol_a), 32'd0);
        chk("rst_pixel", 32'(px_a), 32'd0);
        chk("rst_in_ready", 32'(ir_a), 32'd1);
        chk("rst1_out_valid", 32'(ov_b), 32'd0);
        chk("rst1_in_ready", 32'(ir_b), 32'd1);
        reset  = 1'b0;
        held_v = 1'b0;
        q.delete();
    endtask

    task automatic drain(input int sel);
        for (int k = 0; k < 400 && q.size() > 0; k++) step(sel, 1'b0, 1'b1);
        chk("drain_timeout", 32'(q.size()), 32'd0);
        step(sel, 1'b0, 1'b1);
    endtask

    initial begin
        int cnt;
        int accepted;

        for (int i = 0; i < NT; i++) lanes[i] = 0;
        do_reset();

        // Single word with rounding of small values.
        lanes[0] = 384; lanes[1] = 127; lanes[2] = -384; lanes[3] = 0;
        step(0, 1'b1, 1'b1);
        for (int k = 0; k < 5; k++) step(0, 1'b0, 1'b1);

        // Saturation at both ends.
        lanes[0] = 32'h7FFFFFFF; lanes[1] = 32'h80000000; lanes[2] = 32767; lanes[3] = -32769;
        step(0, 1'b1, 1'b1);
        drain(0);

        // Back-to-back stream: output must stay occupied.
        cnt = 0;
        for (int c = 0; c <= 3 * NT; c++) begin
            rand_lanes();
            step(0, 1'b1, 1'b1);
            if (c > 0 && obs_ov) cnt++;
        end
        chk("b2b_occupancy", 32'(cnt), 32'(3 * NT));
        drain(0);

        // Random backpressure across 100 words.
        accepted = 0;
        for (int c = 0; c < 6000 && accepted < 100; c++) begin
            rand_lanes();
            step(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0));
            if (in_fired) accepted++;
        end
        chk("bp_words_accepted", 32'(accepted), 32'd100);
        drain(0);

        // Reset after two of four pixels, then a fresh word from lane 0.
        rand_lanes();
        step(0, 1'b1, 1'b1);
        step(0, 1'b0, 1'b1);
        step(0, 1'b0, 1'b1);
        do_reset();
        rand_lanes();
        step(0, 1'b1, 1'b1);
        drain(0);

        // Single-lane, no-shift instance.
        lanes[0] = -1000;
        step(1, 1'b1, 1'b1);
        step(1, 1'b1, 1'b1);
        step(1, 1'b0, 1'b1);
        accepted = 0;
        for (int c = 0; c < 400 && accepted < 20; c++) begin
            rand_lanes();
            step(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if (in_fired) accepted++;
        end
        chk("nt1_words_accepted", 32'(accepted), 32'd20);
        drain(1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
